// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the clock divider controller: the controller state
// encoding and the default width of the half-period divide value/counter.
// No ports (package).
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

   // Default width of the half-period divide value and its counter
   localparam int CNT_W_DEFAULT = 4;

   // Controller states: idle, generating, and waiting to finish a high phase
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } ctrlState_t;

endpackage

// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if
// Bundles the control, configuration handshake and output signals of the
// clock divider controller.
//   start, stop     : generation requests (level, sampled each clk)
//   cfg_valid       : a divide value is offered on cfg_div
//   cfg_div         : half-period length in clk cycles
//   cfg_ready       : controller can accept cfg_div this cycle
//   cfg_err         : one-cycle pulse, an accepted cfg_div of 0 was dropped
//   clk_out         : registered divided clock
//   tick            : high in the first cycle of each clk_out high phase
//   busy            : controller is not idle
// Modports: master drives requests/config, slave is the controller.
// ---------------------------------------------------------------------------
interface div_ctrl_if
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) ();

   logic             start;
   logic             stop;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_out;
   logic             tick;
   logic             busy;

   modport master (
      output start, stop, cfg_valid, cfg_div,
      input  cfg_ready, cfg_err, clk_out, tick, busy
   );

   modport slave (
      input  start, stop, cfg_valid, cfg_div,
      output cfg_ready, cfg_err, clk_out, tick, busy
   );

endinterface

// File: rtl/div_period_cnt.sv
// ---------------------------------------------------------------------------
// div_period_cnt
// Half-period counter for the clock divider. Counts 0..i_div-1 while enabled
// and wraps to 0 on the terminal value, so it never runs past i_div-1.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_enable    : advance the counter this cycle
//   i_clear     : force the counter to 0 (wins over i_enable)
//   i_div       : half-period length (1..2^CNT_W-1)
//   o_cnt       : current count
//   o_terminal  : count equals i_div-1 (last cycle of the half period)
// ---------------------------------------------------------------------------
module div_period_cnt
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_div,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_terminal
);

   logic [CNT_W-1:0] r_cnt;

   // Last cycle of the half period; i_div is never 0 so this cannot underflow
   assign o_terminal = (r_cnt == (i_div - CNT_W'(1)));
   assign o_cnt      = r_cnt;

   // Count up while enabled, restarting at 0 after the terminal value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         if (o_terminal) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Programmable clock divider controller. Produces clk_out with period
// 2*div clk cycles, starts on request, stops only at the end of a high phase
// and changes the divide value only on full-period boundaries so no phase is
// ever cut short.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : div_ctrl_if slave (start/stop, cfg handshake, outputs)
// ---------------------------------------------------------------------------
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input logic       clk,
   input logic       rst_n,
   div_ctrl_if.slave bus
);

   ctrlState_t       r_state;
   ctrlState_t       w_nextState;
   logic [CNT_W-1:0] r_divReg;
   logic [CNT_W-1:0] r_pendDiv;
   logic             r_pending;
   logic             r_clkOut;
   logic             r_cfgErr;

   logic [CNT_W-1:0] w_cnt;
   logic             w_terminal;
   logic             w_cntEnable;
   logic             w_cntClear;
   logic             w_rise;
   logic             w_fall;
   logic             w_goIdle;
   logic             w_busy;
   logic             w_cfgReady;
   logic             w_tick;
   logic             w_accept;
   logic             w_acceptOk;
   logic             w_acceptZero;

   div_period_cnt #(
      .CNT_W (CNT_W)
   ) u_periodCnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (w_cntEnable),
      .i_clear    (w_cntClear),
      .i_div      (r_divReg),
      .o_cnt      (w_cnt),
      .o_terminal (w_terminal)
   );

   assign w_accept     = bus.cfg_valid && w_cfgReady;
   assign w_acceptOk   = w_accept && (bus.cfg_div != '0);
   assign w_acceptZero = w_accept && (bus.cfg_div == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; a stop during the low phase ends at once, during the
   // high phase it waits for the falling toggle (immediately if that is now)
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               if (!r_clkOut || w_terminal) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextState = STOP_PEND;
               end
            end
         end
         STOP_PEND: begin
            if (w_terminal) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output and control decode; the counter's first count of a high phase
   // is exactly the cycle in which clk_out has just risen, which gives tick
   always_comb begin
      w_busy      = (r_state != IDLE);
      w_cfgReady  = (r_state == IDLE) || ((r_state == RUN) && !r_pending);
      w_goIdle    = w_busy && (w_nextState == IDLE);
      w_cntEnable = w_busy;
      w_cntClear  = (r_state == IDLE) || w_goIdle;
      w_rise      = (r_state == RUN) && w_terminal && !r_clkOut && !bus.stop;
      w_fall      = w_busy && w_terminal && r_clkOut;
      w_tick      = r_clkOut && (w_cnt == '0);
   end

   // Divide value and pending slot; while running a new value waits for the
   // full-period boundary (falling toggle) or for the stop into idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divReg  <= CNT_W'(1);
         r_pendDiv <= '0;
         r_pending <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_acceptOk) begin
            r_divReg <= bus.cfg_div;
         end
      end else if ((w_fall || w_goIdle) && r_pending) begin
         r_divReg  <= r_pendDiv;
         r_pending <= 1'b0;
      end else if (w_acceptOk) begin
         if (w_goIdle) begin
            r_divReg <= bus.cfg_div;
         end else begin
            r_pendDiv <= bus.cfg_div;
            r_pending <= 1'b1;
         end
      end
   end

   // Divided clock and config error pulse; leaving to idle always forces low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clkOut <= 1'b0;
         r_cfgErr <= 1'b0;
      end else begin
         r_cfgErr <= w_acceptZero;
         if (w_goIdle) begin
            r_clkOut <= 1'b0;
         end else if (w_rise) begin
            r_clkOut <= 1'b1;
         end else if (w_fall) begin
            r_clkOut <= 1'b0;
         end
      end
   end

   assign bus.cfg_ready = w_cfgReady;
   assign bus.cfg_err   = r_cfgErr;
   assign bus.clk_out   = r_clkOut;
   assign bus.tick      = w_tick;
   assign bus.busy      = w_busy;

endmodule
